// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, byte-class thresholds and the
// encoding of the voice parser state.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam logic [7:0] SYSCOM_MIN   = 8'hF0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_KEY  = 2'd1;
    localparam state_t ST_VEL  = 2'd2;

    localparam logic [6:0] RESET_NOTE = 7'd60;

endpackage : midi_pkg

// File: rtl/midi_voice_ctrl.sv
// Monophonic MIDI voice controller: parses note-on/note-off messages (with
// running status) on one channel and drives note/velocity/gate/trig.
module midi_voice_ctrl
    import midi_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int OMNI    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       trig
);

    state_t     state_q, state_d;
    logic       rs_valid_q, rs_valid_d;
    logic       rs_on_q, rs_on_d;
    logic [6:0] key_q, key_d;
    logic [6:0] note_q, note_d;
    logic [6:0] vel_q, vel_d;
    logic       gate_q, gate_d;
    logic       trig_q, trig_d;

    logic       chan_match;
    logic       is_note_status;

    assign chan_match     = (OMNI != 0) || (rx_data[3:0] == 4'(CHANNEL));
    assign is_note_status = (rx_data[7:4] == NOTE_OFF) || (rx_data[7:4] == NOTE_ON);

    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        rs_on_d    = rs_on_q;
        key_d      = key_q;
        note_d     = note_q;
        vel_d      = vel_q;
        gate_d     = gate_q;
        trig_d     = 1'b0;

        // Realtime bytes fall through untouched so they may interleave anywhere.
        if (rx_valid && (rx_data < REALTIME_MIN)) begin
            if (rx_data[7]) begin
                if ((rx_data < SYSCOM_MIN) && is_note_status && chan_match) begin
                    rs_valid_d = 1'b1;
                    rs_on_d    = (rx_data[7:4] == NOTE_ON);
                    state_d    = ST_KEY;
                end else begin
                    rs_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rs_valid_q) begin
                            key_d   = rx_data[6:0];
                            state_d = ST_VEL;
                        end
                    end
                    ST_KEY: begin
                        key_d   = rx_data[6:0];
                        state_d = ST_VEL;
                    end
                    ST_VEL: begin
                        state_d = ST_KEY;
                        if (rs_on_q && (rx_data[6:0] != 7'd0)) begin
                            note_d = key_q;
                            vel_d  = rx_data[6:0];
                            gate_d = 1'b1;
                            trig_d = 1'b1;
                        end else if (gate_q && (key_q == note_q)) begin
                            // Release keeps note and velocity for the envelope tail.
                            gate_d = 1'b0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rs_valid_q <= 1'b0;
            rs_on_q    <= 1'b0;
            key_q      <= 7'd0;
            note_q     <= RESET_NOTE;
            vel_q      <= 7'd0;
            gate_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            rs_on_q    <= rs_on_d;
            key_q      <= key_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            gate_q     <= gate_d;
            trig_q     <= trig_d;
        end
    end

    assign note     = note_q;
    assign velocity = vel_q;
    assign gate     = gate_q;
    assign trig     = trig_q;

endmodule : midi_voice_ctrl

// File: tb/tb_midi_voice_ctrl.sv
// Scoreboard bench for midi_voice_ctrl: a channel-0 instance and an OMNI
// instance share one byte stream; expected outputs are queued per byte.
module tb_midi_voice_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    logic [6:0] note, velocity, o_note, o_velocity;
    logic       gate, trig, o_gate, o_trig;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] byte_v;
        int         exp_note;
        int         exp_vel;
        int         exp_gate;
        int         exp_trig;
        bit         chk_omni;
        int         exp_onote;
        int         exp_ogate;
    } exp_t;

    exp_t sb[$];
    logic sampled_q = 1'b0;

    always #5 clk = ~clk;

    midi_voice_ctrl #(.CHANNEL(0), .OMNI(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .note     (note),
        .velocity (velocity),
        .gate     (gate),
        .trig     (trig)
    );

    midi_voice_ctrl #(.CHANNEL(0), .OMNI(1)) dut_omni (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .note     (o_note),
        .velocity (o_velocity),
        .gate     (o_gate),
        .trig     (o_trig)
    );

    task automatic check(input string tag, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    always @(posedge clk) sampled_q <= rx_valid && !rst;

    // Pop one expectation per consumed byte; otherwise trig must be idle.
    always @(negedge clk) begin
        if (sampled_q) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("byte %02h -> note=%0d vel=%0d gate=%0b trig=%0b",
                         e.byte_v, note, velocity, gate, trig);
                check("note", int'(note), e.exp_note);
                check("velocity", int'(velocity), e.exp_vel);
                check("gate", int'(gate), e.exp_gate);
                check("trig", int'(trig), e.exp_trig);
                if (e.chk_omni) begin
                    check("omni_note", int'(o_note), e.exp_onote);
                    check("omni_gate", int'(o_gate), e.exp_ogate);
                end
            end
        end else begin
            check("trig_idle", int'(trig), 0);
        end
    end

    task automatic send(input logic [7:0] b, input int n, input int v, input int g,
                        input int t, input bit co = 1'b0, input int on = 0,
                        input int og = 0);
        exp_t e;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        e.byte_v = b; e.exp_note = n; e.exp_vel = v; e.exp_gate = g; e.exp_trig = t;
        e.chk_omni = co; e.exp_onote = on; e.exp_ogate = og;
        sb.push_back(e);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        $display("reset check %s: note=%0d vel=%0d gate=%0b trig=%0b",
                 tag, note, velocity, gate, trig);
        check({tag, "_note"}, int'(note), 60);
        check({tag, "_vel"}, int'(velocity), 0);
        check({tag, "_gate"}, int'(gate), 0);
        check({tag, "_trig"}, int'(trig), 0);
    endtask

    task automatic do_reset(input string tag, input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = with_byte;
        rx_data  = b;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        check_reset_values(tag);
    endtask

    initial begin
        #200000;
        check("watchdog", 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("por", 1'b0, 8'h00);

        // Note-on, running status, wrong-key and matching releases.
        send(8'h90, 60, 0, 0, 0);
        send(8'h3C, 60, 0, 0, 0);
        send(8'h64, 60, 100, 1, 1);
        send(8'h3E, 60, 100, 1, 0);
        send(8'h50, 62, 80, 1, 1);
        send(8'h3C, 62, 80, 1, 0);
        send(8'h00, 62, 80, 1, 0);
        send(8'h3E, 62, 80, 1, 0);
        send(8'h00, 62, 80, 0, 0);

        // Realtime bytes interleaved mid-message.
        send(8'h90, 62, 80, 0, 0);
        send(8'hF8, 62, 80, 0, 0);
        send(8'h40, 62, 80, 0, 0);
        send(8'hFE, 62, 80, 0, 0);
        send(8'h7F, 64, 127, 1, 1);

        // Explicit note-off status keeps pitch and velocity.
        send(8'h80, 64, 127, 1, 0);
        send(8'h40, 64, 127, 1, 0);
        send(8'h00, 64, 127, 0, 0);

        // Channel 1 message: ignored on channel 0, accepted in OMNI.
        do_reset("rst_chan", 1'b0, 8'h00);
        send(8'h91, 60, 0, 0, 0);
        send(8'h3C, 60, 0, 0, 0);
        send(8'h64, 60, 0, 0, 0, 1'b1, 60, 1);

        // Control change aborts the note and clears running status.
        do_reset("rst_cc", 1'b0, 8'h00);
        send(8'h90, 60, 0, 0, 0);
        send(8'h3C, 60, 0, 0, 0);
        send(8'hB0, 60, 0, 0, 0);
        send(8'h07, 60, 0, 0, 0);
        send(8'h7F, 60, 0, 0, 0);
        send(8'h3C, 60, 0, 0, 0);
        send(8'h64, 60, 0, 0, 0, 1'b1, 60, 0);

        // Reset mid-message, then reset colliding with the velocity byte.
        send(8'h90, 60, 0, 0, 0);
        send(8'h3C, 60, 0, 0, 0);
        do_reset("rst_mid", 1'b0, 8'h00);
        send(8'h64, 60, 0, 0, 0, 1'b1, 60, 0);
        send(8'h90, 60, 0, 0, 0);
        send(8'h3C, 60, 0, 0, 0);
        do_reset("rst_coll", 1'b1, 8'h64);
        send(8'h64, 60, 0, 0, 0, 1'b1, 60, 0);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_midi_voice_ctrl
